// File: rtl/core_pkg.sv
// Shared definitions for the core_seq instruction sequencer: FSM state
// encoding, the supported opcode set and the illegal-opcode check.
package core_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    function automatic logic is_illegal(input logic [6:0] op);
        case (op)
            OP_REG, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL: return 1'b0;
            default:                                             return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/core_seq_bus_timeout.sv
// Bus handshake wait counter: a down-counter reloaded on clear, decremented
// while enabled, flagging expiry once TIMEOUT_CYC wait cycles have elapsed.
module bus_timeout #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [15:0] LOAD_VAL = 16'(TIMEOUT_CYC);

    logic [15:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= LOAD_VAL;
        end else if (clr) begin
            cnt <= LOAD_VAL;
        end else if (en && (cnt != 16'd0)) begin
            cnt <= cnt - 16'd1;
        end
    end

    // Terminal count: the cycle after TIMEOUT_CYC ack-less cycles.
    assign expired = en && (cnt == 16'd0);

endmodule

// File: rtl/core_seq.sv
// Multi-cycle fetch/decode/execute sequencer with bus timeouts.
// Optional performance counters are built when CORE_SEQ_PERF_EN is defined.
//
// state  | meaning
// FETCH  | imem request high, wait for instruction ack
// DECODE | one cycle, reject unsupported opcodes
// EXEC   | one cycle, choose MEM or WB
// MEM    | dmem request high, wait for data ack
// WB     | one cycle register write strobe, retire
// HALT   | sticky stop until reset
module core_seq
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        imem_req_o,
    input  logic        imem_ack_i,
    input  logic [31:0] inst_i,
    output logic [31:0] ir_o,
    input  logic        mem_rd_i,
    input  logic        mem_wr_i,
    input  logic        reg_wr_i,
    input  logic        br_taken_i,
    input  logic [31:0] alu_res_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    input  logic        dmem_ack_i,
    output logic [31:0] pc_o,
    output logic        reg_wr_o,
    output logic        halt_o,
    output logic        illegal_o,
    output logic        bus_err_o,
`ifdef CORE_SEQ_PERF_EN
    output logic [2:0]  state_o,
    output logic [31:0] cycle_cnt_o,
    output logic [31:0] instret_o
`else
    output logic [2:0]  state_o
`endif
);

    state_t     state, state_nxt;
    logic [6:0] opcode;
    logic       redirect, misaligned;
    logic       fetch, retire, ir_load, set_illegal, set_bus_err;
    logic       wait_clr, wait_en, wait_expired;

    assign opcode     = ir_o[6:0];
    assign redirect   = ((opcode == OP_BRANCH) && br_taken_i) || (opcode == OP_JAL);
    assign misaligned = redirect && (alu_res_i[1:0] != 2'b00);

    always_comb begin
        state_nxt   = state;
        fetch       = 1'b0;
        ir_load     = 1'b0;
        retire      = 1'b0;
        set_illegal = 1'b0;
        set_bus_err = 1'b0;
        dmem_req_o  = 1'b0;
        dmem_we_o   = 1'b0;
        reg_wr_o    = 1'b0;
        case (state)
            ST_FETCH: begin
                fetch = 1'b1;
                if (imem_ack_i) begin
                    ir_load   = 1'b1;
                    state_nxt = ST_DECODE;
                end else if (wait_expired) begin
                    set_bus_err = 1'b1;
                    state_nxt   = ST_HALT;
                end
            end
            ST_DECODE: begin
                if (is_illegal(opcode)) begin
                    set_illegal = 1'b1;
                    state_nxt   = ST_HALT;
                end else begin
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: state_nxt = (mem_rd_i || mem_wr_i) ? ST_MEM : ST_WB;
            ST_MEM: begin
                dmem_req_o = 1'b1;
                dmem_we_o  = mem_wr_i;
                if (dmem_ack_i) begin
                    retire    = mem_wr_i;
                    state_nxt = mem_wr_i ? ST_FETCH : ST_WB;
                end else if (wait_expired) begin
                    set_bus_err = 1'b1;
                    state_nxt   = ST_HALT;
                end
            end
            ST_WB: begin
                reg_wr_o  = reg_wr_i;
                retire    = 1'b1;
                state_nxt = ST_FETCH;
            end
            default: state_nxt = ST_HALT;
        endcase
        // A misaligned redirect aborts the retire and leaves the PC untouched.
        if (retire && misaligned) begin
            set_bus_err = 1'b1;
            state_nxt   = ST_HALT;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= ST_FETCH;
            pc_o      <= RESET_PC;
            ir_o      <= 32'd0;
            illegal_o <= 1'b0;
            bus_err_o <= 1'b0;
        end else begin
            state <= state_nxt;
            if (ir_load) ir_o <= inst_i;
            if (retire && !misaligned) pc_o <= redirect ? alu_res_i : pc_o + 32'd4;
            if (set_illegal) illegal_o <= 1'b1;
            if (set_bus_err) bus_err_o <= 1'b1;
        end
    end

    assign wait_en  = (state == ST_FETCH) || (state == ST_MEM);
    assign wait_clr = (state_nxt != state) && ((state_nxt == ST_FETCH) || (state_nxt == ST_MEM));

    bus_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .clk     (clk_i),
        .rst_n   (rst_ni),
        .clr     (wait_clr),
        .en      (wait_en),
        .expired (wait_expired)
    );

    // Gate with reset so the fetch request is low while reset is held.
    assign imem_req_o = fetch && rst_ni;
    assign halt_o     = (state == ST_HALT);
    assign state_o    = state;

`ifdef CORE_SEQ_PERF_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cycle_cnt_o <= 32'd0;
            instret_o   <= 32'd0;
        end else begin
            if (state != ST_HALT) cycle_cnt_o <= cycle_cnt_o + 32'd1;
            if (retire && !misaligned) instret_o <= instret_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_core_seq.sv
// Randomized bench for core_seq: per-instruction latency, PC, strobe and
// flag expectations come from a transaction-level model kept here.
module tb_core_seq;

    localparam int          TO   = 4;
    localparam logic [31:0] RPC  = 32'h0000_0000;
    localparam logic [6:0]  O_REG = 7'b0110011, O_IMM = 7'b0010011, O_LD = 7'b0000011;
    localparam logic [6:0]  O_ST  = 7'b0100011, O_BR  = 7'b1100011, O_JAL = 7'b1101111;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        imem_ack_i = 1'b0, dmem_ack_i = 1'b0;
    logic [31:0] inst_i = 32'd0, alu_res_i = 32'd0;
    logic        mem_rd_i = 1'b0, mem_wr_i = 1'b0, reg_wr_i = 1'b0, br_taken_i = 1'b0;
    logic        imem_req_o, dmem_req_o, dmem_we_o, reg_wr_o, halt_o, illegal_o, bus_err_o;
    logic [31:0] ir_o, pc_o;
    logic [2:0]  state_o;

    int          total = 0;
    int          bad = 0;
    logic [31:0] mpc;

    core_seq #(.RESET_PC(RPC), .TIMEOUT_CYC(TO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .imem_req_o(imem_req_o), .imem_ack_i(imem_ack_i), .inst_i(inst_i), .ir_o(ir_o),
        .mem_rd_i(mem_rd_i), .mem_wr_i(mem_wr_i), .reg_wr_i(reg_wr_i),
        .br_taken_i(br_taken_i), .alu_res_i(alu_res_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_ack_i(dmem_ack_i),
        .pc_o(pc_o), .reg_wr_o(reg_wr_o), .halt_o(halt_o), .illegal_o(illegal_o),
        .bus_err_o(bus_err_o), .state_o(state_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(posedge clk_i); #1;
        rst_ni = 1'b0;
        imem_ack_i = 1'b0;
        dmem_ack_i = 1'b0;
        #1;
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_pc", pc_o, RPC);
        check("rst_ir", ir_o, 32'd0);
        check("rst_flags", {29'd0, halt_o, illegal_o, bus_err_o}, 32'd0);
        check("rst_reqs", {29'd0, imem_req_o, dmem_req_o, reg_wr_o}, 32'd0);
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        #1 check("rst_imem_req", 32'(imem_req_o), 32'd1);
        mpc = RPC;
    endtask

    // Entry: inside the first FETCH cycle, before its closing clock edge.
    task automatic run_instr(input logic [31:0] inst, input int fw, input int mw,
                             input logic rw, input logic bt, input logic [31:0] alu);
        logic [6:0]  op;
        logic        ld, st, mem, ill, redir;
        int          e_lat, e_wr, e_dm;
        logic        e_halt, e_be, e_il;
        logic [31:0] e_pc;
        int          cyc, fcnt, mcnt, wr, dm, we_bad;
        logic        fetched, done;
        op    = inst[6:0];
        ld    = (op == O_LD);
        st    = (op == O_ST);
        mem   = ld || st;
        ill   = !(op inside {O_REG, O_IMM, O_LD, O_ST, O_BR, O_JAL});
        redir = ((op == O_BR) && bt) || (op == O_JAL);
        e_halt = 1'b0; e_be = 1'b0; e_il = 1'b0; e_pc = mpc; e_wr = 0; e_dm = 0;
        if (fw > TO) begin
            e_lat = TO + 1; e_be = 1'b1; e_halt = 1'b1;
        end else if (ill) begin
            e_lat = fw + 2; e_il = 1'b1; e_halt = 1'b1;
        end else if (mem && mw > TO) begin
            e_lat = fw + TO + 4; e_be = 1'b1; e_halt = 1'b1; e_dm = TO + 1;
        end else begin
            e_lat = fw + (ld ? 5 : 4) + (mem ? mw : 0);
            e_dm  = mem ? mw + 1 : 0;
            e_wr  = (st || !rw) ? 0 : 1;
            if (redir && alu[1:0] != 2'b00) begin
                e_be = 1'b1; e_halt = 1'b1;
            end else begin
                e_pc = redir ? alu : mpc + 32'd4;
            end
        end
        mem_rd_i = ld; mem_wr_i = st; reg_wr_i = rw; br_taken_i = bt; alu_res_i = alu;
        cyc = 1; fcnt = 0; mcnt = 0; wr = 0; dm = 0; we_bad = 0;
        fetched = 1'b0; done = 1'b0;
        while (cyc <= 40 && !done) begin
            imem_ack_i = 1'b0;
            dmem_ack_i = 1'b0;
            inst_i = $urandom;
            if (imem_req_o) begin
                if (fcnt == fw) begin
                    imem_ack_i = 1'b1; inst_i = inst; fetched = 1'b1;
                end
                fcnt++;
            end else if ($urandom_range(0, 3) == 0) begin
                imem_ack_i = 1'b1;
            end
            if (dmem_req_o) begin
                dm++;
                if (dmem_we_o !== st) we_bad++;
                if (mcnt == mw) dmem_ack_i = 1'b1;
                mcnt++;
            end else if ($urandom_range(0, 3) == 0) begin
                dmem_ack_i = 1'b1;
            end
            if (reg_wr_o) wr++;
            @(posedge clk_i); #1;
            cyc++;
            if (halt_o || (fetched && imem_req_o)) done = 1'b1;
        end
        imem_ack_i = 1'b0;
        dmem_ack_i = 1'b0;
        if (!done) check("cycle_budget", 32'd0, 32'd1);
        else       check("latency", 32'(cyc - 1), 32'(e_lat));
        check("pc", pc_o, e_pc);
        check("reg_wr_pulses", 32'(wr), 32'(e_wr));
        check("dmem_req_cycles", 32'(dm), 32'(e_dm));
        check("dmem_we", 32'(we_bad), 32'd0);
        check("halt", 32'(halt_o), 32'(e_halt));
        check("bus_err", 32'(bus_err_o), 32'(e_be));
        check("illegal", 32'(illegal_o), 32'(e_il));
        if (fw <= TO) check("ir", ir_o, inst);
        mpc = e_pc;
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op);
        logic [31:0] r;
        r = $urandom;
        return {r[31:7], op};
    endfunction

    initial begin
        logic [6:0]  ops [7];
        logic [6:0]  op;
        logic [31:0] alu;
        int          fw, mw;
        ops = '{O_REG, O_IMM, O_LD, O_ST, O_BR, O_JAL, 7'b1111111};

        do_reset();
        // ADD, ack in first cycle
        run_instr(mk(O_REG), 0, 0, 1'b1, 1'b0, 32'h1234_5678);
        // load, data ack after 3 wait cycles
        run_instr(mk(O_LD), 0, 3, 1'b1, 1'b0, 32'h0000_0100);
        // taken branch to an aligned target
        run_instr(mk(O_BR), 1, 0, 1'b0, 1'b1, 32'h0000_0040);
        // store, then instruction ack exactly on the expiry cycle
        run_instr(mk(O_ST), 2, 1, 1'b1, 1'b0, 32'h0000_0200);
        run_instr(mk(O_IMM), TO, 0, 1'b1, 1'b0, 32'h0);
        run_instr(mk(O_LD), 0, TO, 1'b1, 1'b0, 32'h0);
        run_instr(mk(O_JAL), 0, 0, 1'b1, 1'b0, 32'hFFFF_FFFC);
        run_instr(mk(O_REG), 0, 0, 1'b0, 1'b0, 32'h0);

        // misaligned branch target
        run_instr(mk(O_BR), 0, 0, 1'b0, 1'b1, 32'h0000_0042);
        do_reset();

        // illegal opcode: fetch stays quiet afterwards
        run_instr(mk(7'b1111111), 0, 0, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_i); #1;
            check("halt_imem_req", 32'(imem_req_o), 32'd0);
            check("halt_state", 32'(state_o), 32'd5);
        end
        do_reset();

        // instruction and data timeouts
        run_instr(mk(O_REG), TO + 3, 0, 1'b1, 1'b0, 32'h0);
        do_reset();
        run_instr(mk(O_ST), 0, TO + 1, 1'b0, 1'b0, 32'h0);
        do_reset();

        // reset asserted mid data handshake
        run_instr(mk(O_REG), 0, 0, 1'b1, 1'b0, 32'h0);
        mem_rd_i = 1'b1; mem_wr_i = 1'b0;
        for (int i = 0; i < 10 && !dmem_req_o; i++) begin
            imem_ack_i = imem_req_o;
            inst_i = mk(O_LD);
            @(posedge clk_i); #1;
            imem_ack_i = 1'b0;
        end
        check("mid_mem_req", 32'(dmem_req_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        check("mid_rst_dmem_req", 32'(dmem_req_o), 32'd0);
        check("mid_rst_imem_req", 32'(imem_req_o), 32'd0);
        check("mid_rst_pc", pc_o, RPC);
        check("mid_rst_state", 32'(state_o), 32'd0);
        do_reset();

        for (int n = 0; n < 60; n++) begin
            op  = ($urandom_range(0, 11) == 0) ? ops[6] : ops[$urandom_range(0, 5)];
            fw  = ($urandom_range(0, 9) == 0) ? TO + 2 : int'($urandom_range(0, TO));
            mw  = ($urandom_range(0, 9) == 0) ? TO + 1 : int'($urandom_range(0, TO));
            alu = $urandom;
            if ($urandom_range(0, 7) != 0) alu[1:0] = 2'b00;
            run_instr(mk(op), fw, mw, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), alu);
            if (halt_o) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/core_seq.md
CORE_SEQ -- requirements
Module: core_seq

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, the PC value loaded at reset.
REQ-002 Parameter TIMEOUT_CYC, 255, the maximum number of wait cycles for an ack before a bus error (range 1..65535).
REQ-003 clk_i  in  1  the single clock; all state changes on its rising edge.
REQ-004 rst_ni  in  1  the reset, asynchronous and active-low.
REQ-005 imem_req_o  out  1  the instruction fetch request, held high until ack.
REQ-006 imem_ack_i  in  1  a one-cycle pulse; inst_i is valid in the same cycle.
REQ-007 inst_i  in  32  the fetched instruction.
REQ-008 ir_o  out  32  the latched instruction register; it drives the decoder.
REQ-009 mem_rd_i, mem_wr_i, reg_wr_i  in  1 each  the decoder control outputs for ir_o.
REQ-010 br_taken_i  in  1  the branch comparator result for ir_o.
REQ-011 alu_res_i  in  32  the ALU result; it is the address or branch/jump target.
REQ-012 dmem_req_o  out  1  the data request, held high until ack; dmem_we_o  out  1  the write enable, valid while dmem_req_o is high.
REQ-013 dmem_ack_i  in  1  a one-cycle data ack.
REQ-014 pc_o  out  32  the current PC register.
REQ-015 reg_wr_o  out  1  the register-file write strobe; it is a one-cycle pulse.
REQ-016 halt_o  out  1  sticky; illegal_o  out  1  sticky; bus_err_o  out  1  sticky.
REQ-017 state_o  out  3  the FSM state encoding, for debug.

Function
REQ-018 FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-019 In FETCH, imem_req_o=1 and pc_o is the fetch address; on imem_ack_i the block SHALL set ir_o<=inst_i and go to DECODE.
REQ-020 DECODE lasts one cycle; an opcode outside {0110011, 0010011, 0000011, 0100011, 1100011, 1101111} SHALL set illegal_o and go to HALT.
REQ-021 EXEC lasts one cycle; next state is MEM if mem_rd_i|mem_wr_i, else WB.
REQ-022 In MEM, dmem_req_o=1 and dmem_we_o=mem_wr_i; on dmem_ack_i, a load goes to WB and a store retires and goes to FETCH.
REQ-023 WB lasts one cycle: reg_wr_o=reg_wr_i, then retire and go to FETCH.
REQ-024 On retire, the PC update SHALL be pc_o<=alu_res_i if (opcode 1100011 & br_taken_i) or opcode 1101111, else pc_o<=pc_o+4 (modulo 2^32, wraps).
REQ-025 A redirect target with alu_res_i[1:0]!=0 SHALL set bus_err_o, go to HALT, and leave pc_o unchanged.
REQ-026 Latency from the first FETCH cycle, with ack in that cycle: ALU/branch/jal 4 cycles, store 4 cycles, load 5 cycles; each ack wait cycle adds 1.
REQ-027 The wait counter SHALL clear on entry to FETCH or MEM; if TIMEOUT_CYC cycles elapse without ack, set bus_err_o and go to HALT.
REQ-028 An ack arriving while the matching req is low SHALL be ignored; an ack in the same cycle as a timeout SHALL win, meaning no error is raised.
REQ-029 HALT: all requests and strobes are 0, halt_o=1, and the state is held until reset.
REQ-030 reg_wr_o SHALL be 0 in every state except WB.

Reset
REQ-031 Asserting rst_ni at any time, including mid-handshake, SHALL immediately set state=FETCH, pc_o=RESET_PC, ir_o=0, all sticky flags 0, and reg_wr_o=0. imem_req_o and dmem_req_o SHALL be 0 while reset is asserted.
REQ-032 imem_req_o SHALL go high in the first clock cycle after rst_ni deasserts.

Configuration
REQ-033 Macro CORE_SEQ_PERF_EN: when defined, add outputs cycle_cnt_o[31:0] and instret_o[31:0].
REQ-034 cycle_cnt_o SHALL increment every cycle outside HALT; instret_o SHALL increment on each retire. Both clear on reset and wrap at 2^32.
REQ-035 When CORE_SEQ_PERF_EN is undefined, these ports and counters SHALL be absent and all other behaviour identical.

Structure
REQ-036 Shared package core_pkg SHALL hold the state enum, the opcode localparams, and the illegal-opcode check function.
REQ-037 Sub-module bus_timeout (wait counter with clear, enable, and expire outputs) SHALL be instantiated once.

Verification
REQ-038 ADD with ack in the first cycle -> states FETCH,DECODE,EXEC,WB; reg_wr_o pulse in cycle 4; pc_o 0->4.
REQ-039 Load with dmem_ack_i after 3 wait cycles -> dmem_req_o high for 4 cycles, then WB; 8 cycles total.
REQ-040 Taken BEQ with alu_res_i=32'h40 -> pc_o=32'h40, no reg_wr_o; with alu_res_i=32'h42 -> bus_err_o=1, HALT.
REQ-041 inst_i opcode 7'b1111111 -> illegal_o=1 and halt_o=1 after DECODE; imem_req_o stays 0 thereafter.
REQ-042 No imem_ack_i, with TIMEOUT_CYC=4 -> bus_err_o rises after 4 wait cycles; an ack on the expiry cycle -> no error.
REQ-043 rst_ni pulsed low during MEM -> dmem_req_o drops immediately, pc_o=RESET_PC; with CORE_SEQ_PERF_EN, counters read 0.
